// File: rtl/qb_core_pkg.sv
// Shared constants and elaboration-time helpers for the serial byte collector.
package qb_core_pkg;

    localparam int QB_DEFAULT_WIDTH = 8;

    // True when w is a power of two no smaller than 2.
    function automatic bit qb_is_pow2(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/qb_bit_counter.sv
// Modulo-WIDTH bit counter with enable and asynchronous reset; flags the last bit slot.
module qb_bit_counter
    import qb_core_pkg::*;
#(
    parameter int WIDTH = QB_DEFAULT_WIDTH,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // WIDTH is a power of two, so the natural binary rollover is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/qb_core.sv
// Serial-to-parallel collector: MSB-first shift register with a word-complete carry-out.
module qb_core
    import qb_core_pkg::*;
#(
    parameter int WIDTH = QB_DEFAULT_WIDTH
) (
    input  logic             rst,
    input  logic             en,
    input  logic             si,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    output logic             co
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;
    logic          tc;

    if (!qb_is_pow2(WIDTH)) begin : g_width_check
        $error("qb_core: WIDTH must be a power of two >= 2");
    end

    qb_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .cnt (cnt),
        .tc  (tc)
    );

    // First bit received migrates to the MSB after WIDTH enabled shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (en) begin
            out <= {out[WIDTH-2:0], si};
        end
    end

    // co is high during the cycle whose rising edge captures the final bit of a word.
    assign co = en & tc;

endmodule

// File: tb/tb_qb_core.sv
// Scoreboard bench for qb_core: reference model tracks the received bit history.
module tb_qb_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         si;
    logic [W-1:0] out;
    logic         co;

    int n_cmp = 0;
    int n_err = 0;
    int co_pulses = 0;

    logic [W-1:0] exp_q[$];
    logic         co_q[$];
    logic [W-1:0] word_q[$];

    // Reference model: the bits received since reset, oldest first, and their total count.
    bit hist[$];
    int nbits;
    bit co_seen = 1'b0;

    always #5 clk = ~clk;

    qb_core #(.WIDTH(W)) dut (
        .rst (rst),
        .en  (en),
        .si  (si),
        .clk (clk),
        .out (out),
        .co  (co)
    );

    function automatic logic [W-1:0] model_out();
        logic [W-1:0] r = '0;
        for (int i = 0; i < hist.size(); i++) begin
            r = (r << 1) | W'(hist[i]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, expectations are queued.
    task automatic step(input bit e, input bit s);
        bit exp_co;
        @(negedge clk);
        en = e;
        si = s;
        exp_co = e && ((nbits % W) == W - 1);
        co_q.push_back(exp_co);
        if (e) begin
            hist.push_back(s);
            if (hist.size() > W) void'(hist.pop_front());
            nbits++;
        end
        if (exp_co) word_q.push_back(model_out());
        exp_q.push_back(model_out());
    endtask

    // Pulses rst well away from any rising edge and checks the immediate clear.
    task automatic do_reset();
        @(negedge clk);
        #2;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out", out, '0);
        check("rst_co", W'(co), '0);
        hist.delete();
        nbits = 0;
        #1;
        rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        #1;
        if (co_q.size() > 0) begin
            check("co", W'(co), W'(co_q.pop_front()));
            co_seen = co;
        end else begin
            co_seen = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) check("out", out, exp_q.pop_front());
        if (co_seen) begin
            co_pulses++;
            if (word_q.size() > 0) begin
                check("word", out, word_q.pop_front());
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL word_unexpected: got 0x%h with no word pending", out);
            end
            co_seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat2;
        logic [7:0] pat4;
        pat2  = 8'b1011_0110;
        pat4  = 8'b1010_0101;
        nbits = 0;
        rst   = 1'b0;
        en    = 1'b0;

        // Reset with no clock edge in between.
        #2;
        rst = 1'b1;
        #1;
        check("t1_rst_out", out, '0);
        check("t1_rst_co", W'(co), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        settle();
        check("t1_idle_out", out, '0);

        // Byte capture.
        for (int i = 7; i >= 0; i--) step(1'b1, pat2[i]);
        settle();
        check("t2_byte", out, 8'hB6);

        // Hold with en low.
        repeat (8) step(1'b0, 1'b1);
        settle();
        check("t3_hold", out, 8'hB6);

        // Pause mid-word.
        for (int i = 7; i >= 4; i--) step(1'b1, pat4[i]);
        repeat (3) step(1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) step(1'b1, pat4[i]);
        settle();
        check("t4_pause", out, 8'hA5);

        // Back-to-back words.
        co_pulses = 0;
        repeat (16) step(1'b1, 1'b1);
        settle();
        check("t5_ff", out, 8'hFF);
        check("t5_pulses", W'(co_pulses), W'(2));

        // Asynchronous reset after a partial word, then a fresh word.
        repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
        do_reset();
        repeat (8) step(1'b1, 1'($urandom_range(0, 1)));
        settle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end
        settle();
        settle();

        n_cmp++;
        if (exp_q.size() != 0 || co_q.size() != 0 || word_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0",
                     exp_q.size(), co_q.size(), word_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
